// File: rtl/decode_issue_queue.sv
// Decode-to-dispatch issue queue: DEPTH-entry packet FIFO plus an output register with valid/ready.
// Optional macro DECODE_ISSUE_QUEUE_BYPASS_EN lets a packet skip the empty array straight into the output register.
module decode_issue_queue #(
  parameter int DEPTH            = 8,
  parameter int SKID             = 3,
  parameter int addressSize      = 64,
  parameter int immWidth         = 24,
  parameter int regWidth         = 5,
  parameter int opcodeWidth      = 6,
  parameter int XxoOpcodeWidth   = 10,
  parameter int formatIndexRange = 5
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic                          enable_i,
  input  logic [immWidth-1:0]           imm_i,
  input  logic                          immEnable_i,
  input  logic [regWidth-1:0]           reg1_i,
  input  logic [regWidth-1:0]           reg2_i,
  input  logic [regWidth-1:0]           reg3_i,
  input  logic [1:0]                    reg1Use_i,
  input  logic [1:0]                    reg2Use_i,
  input  logic [1:0]                    reg3Use_i,
  input  logic                          reg1Enable_i,
  input  logic                          reg2Enable_i,
  input  logic                          reg3Enable_i,
  input  logic                          reg3IsImmediate_i,
  input  logic                          bit1_i,
  input  logic                          bit2_i,
  input  logic                          reg2ValOrZero_i,
  input  logic [addressSize-1:0]        instructionAddress_i,
  input  logic [opcodeWidth-1:0]        opcode_i,
  input  logic [XxoOpcodeWidth-1:0]     xOpcode_i,
  input  logic                          xOpcodeEnable_i,
  input  logic [2:0]                    functionalUnitCode_i,
  input  logic [formatIndexRange-1:0]   instructionFormat_i,
  output logic [immWidth-1:0]           imm_o,
  output logic                          immEnable_o,
  output logic [regWidth-1:0]           reg1_o,
  output logic [regWidth-1:0]           reg2_o,
  output logic [regWidth-1:0]           reg3_o,
  output logic [1:0]                    reg1Use_o,
  output logic [1:0]                    reg2Use_o,
  output logic [1:0]                    reg3Use_o,
  output logic                          reg1Enable_o,
  output logic                          reg2Enable_o,
  output logic                          reg3Enable_o,
  output logic                          reg3IsImmediate_o,
  output logic                          bit1_o,
  output logic                          bit2_o,
  output logic                          reg2ValOrZero_o,
  output logic [addressSize-1:0]        instructionAddress_o,
  output logic [opcodeWidth-1:0]        opcode_o,
  output logic [XxoOpcodeWidth-1:0]     xOpcode_o,
  output logic                          xOpcodeEnable_o,
  output logic [2:0]                    functionalUnitCode_o,
  output logic [formatIndexRange-1:0]   instructionFormat_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          stall_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          overflow_o
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int PKT_W = immWidth + 1 + 3*regWidth + 6 + 7 + addressSize + opcodeWidth
                         + XxoOpcodeWidth + 1 + 3 + formatIndexRange;

  // Handshake: dispatch takes the packet on any edge where valid_o && ready_i; the
  // output register then reloads from the head (or bypass) in that same edge.
  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [PKT_W-1:0] r_out_pkt;
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  logic             r_valid, r_stall, r_overflow;

  logic [PKT_W-1:0] w_in_pkt;
  logic             w_out_free, w_pop, w_accept, w_bypass, w_write;
  logic [CW-1:0]    w_count_next;

  assign w_in_pkt = {imm_i, immEnable_i, reg1_i, reg2_i, reg3_i, reg1Use_i, reg2Use_i, reg3Use_i,
                     reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i, bit1_i, bit2_i,
                     reg2ValOrZero_i, instructionAddress_i, opcode_i, xOpcode_i, xOpcodeEnable_i,
                     functionalUnitCode_i, instructionFormat_i};

  assign {imm_o, immEnable_o, reg1_o, reg2_o, reg3_o, reg1Use_o, reg2Use_o, reg3Use_o,
          reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o, bit1_o, bit2_o,
          reg2ValOrZero_o, instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o,
          functionalUnitCode_o, instructionFormat_o} = r_out_pkt;

  assign w_out_free = !r_valid || ready_i;
  assign w_pop      = !reset_i && !flush_i && w_out_free && (r_count != '0);
  assign w_accept   = enable_i && ((r_count < CW'(DEPTH)) || w_pop);
`ifdef DECODE_ISSUE_QUEUE_BYPASS_EN
  // Empty array and free output register: the packet goes straight to dispatch.
  assign w_bypass   = !reset_i && !flush_i && enable_i && w_out_free && (r_count == '0);
`else
  assign w_bypass   = 1'b0;
`endif
  assign w_write      = !reset_i && !flush_i && w_accept && !w_bypass;
  assign w_count_next = r_count + CW'(w_write) - CW'(w_pop);

  always_ff @(posedge clock_i) begin
    if (w_write) r_mem[r_tail] <= w_in_pkt;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_out_pkt  <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      if (w_write) r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_head    <= r_head + 1'b1;
        r_out_pkt <= r_mem[r_head];
        r_valid   <= 1'b1;
      end else if (w_bypass) begin
        r_out_pkt <= w_in_pkt;
        r_valid   <= 1'b1;
      end else if (w_out_free) begin
        r_valid <= 1'b0;
      end
      r_count <= w_count_next;
      r_stall <= (w_count_next >= CW'(DEPTH - SKID));
      if (enable_i && !w_accept) r_overflow <= 1'b1;
    end
  end

  assign valid_o    = r_valid;
  assign stall_o    = r_stall;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;
endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: packets queued in exp_q on drive, checked in order on consume.
module tb_decode_issue_queue;
  logic        clock_i = 1'b0;
  logic        reset_i, flush_i, enable_i, ready_i;
  logic [23:0] imm_i;        logic immEnable_i;
  logic [4:0]  reg1_i, reg2_i, reg3_i;
  logic [1:0]  reg1Use_i, reg2Use_i, reg3Use_i;
  logic        reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i, bit1_i, bit2_i, reg2ValOrZero_i;
  logic [63:0] instructionAddress_i; logic [5:0] opcode_i; logic [9:0] xOpcode_i;
  logic        xOpcodeEnable_i; logic [2:0] functionalUnitCode_i; logic [4:0] instructionFormat_i;
  logic [23:0] imm_o;        logic immEnable_o;
  logic [4:0]  reg1_o, reg2_o, reg3_o;
  logic [1:0]  reg1Use_o, reg2Use_o, reg3Use_o;
  logic        reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o, bit1_o, bit2_o, reg2ValOrZero_o;
  logic [63:0] instructionAddress_o; logic [5:0] opcode_o; logic [9:0] xOpcode_o;
  logic        xOpcodeEnable_o; logic [2:0] functionalUnitCode_o; logic [4:0] instructionFormat_o;
  logic        valid_o, stall_o, overflow_o;
  logic [3:0]  count_o;

  logic [141:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  decode_issue_queue dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
    .imm_i(imm_i), .immEnable_i(immEnable_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .reg3_i(reg3_i),
    .reg1Use_i(reg1Use_i), .reg2Use_i(reg2Use_i), .reg3Use_i(reg3Use_i),
    .reg1Enable_i(reg1Enable_i), .reg2Enable_i(reg2Enable_i), .reg3Enable_i(reg3Enable_i),
    .reg3IsImmediate_i(reg3IsImmediate_i), .bit1_i(bit1_i), .bit2_i(bit2_i), .reg2ValOrZero_i(reg2ValOrZero_i),
    .instructionAddress_i(instructionAddress_i), .opcode_i(opcode_i), .xOpcode_i(xOpcode_i),
    .xOpcodeEnable_i(xOpcodeEnable_i), .functionalUnitCode_i(functionalUnitCode_i),
    .instructionFormat_i(instructionFormat_i),
    .imm_o(imm_o), .immEnable_o(immEnable_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
    .reg1Use_o(reg1Use_o), .reg2Use_o(reg2Use_o), .reg3Use_o(reg3Use_o),
    .reg1Enable_o(reg1Enable_o), .reg2Enable_o(reg2Enable_o), .reg3Enable_o(reg3Enable_o),
    .reg3IsImmediate_o(reg3IsImmediate_o), .bit1_o(bit1_o), .bit2_o(bit2_o), .reg2ValOrZero_o(reg2ValOrZero_o),
    .instructionAddress_o(instructionAddress_o), .opcode_o(opcode_o), .xOpcode_o(xOpcode_o),
    .xOpcodeEnable_o(xOpcodeEnable_o), .functionalUnitCode_o(functionalUnitCode_o),
    .instructionFormat_o(instructionFormat_o),
    .valid_o(valid_o), .ready_i(ready_i), .stall_o(stall_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  // Clock / reset block
  always #5 clock_i = ~clock_i;

  function automatic logic [141:0] in_pkt();
    return {imm_i, immEnable_i, reg1_i, reg2_i, reg3_i, reg1Use_i, reg2Use_i, reg3Use_i,
            reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i, bit1_i, bit2_i,
            reg2ValOrZero_i, instructionAddress_i, opcode_i, xOpcode_i, xOpcodeEnable_i,
            functionalUnitCode_i, instructionFormat_i};
  endfunction

  function automatic logic [141:0] out_pkt();
    return {imm_o, immEnable_o, reg1_o, reg2_o, reg3_o, reg1Use_o, reg2Use_o, reg3Use_o,
            reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o, bit1_o, bit2_o,
            reg2ValOrZero_o, instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o,
            functionalUnitCode_o, instructionFormat_o};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic send(input logic [63:0] addr, input logic [5:0] opc, input bit expect_out);
    enable_i             = 1'b1;
    imm_i                = 24'($urandom);
    immEnable_i          = 1'($urandom_range(1));
    reg1_i               = 5'($urandom_range(31));
    reg2_i               = 5'($urandom_range(31));
    reg3_i               = 5'($urandom_range(31));
    reg1Use_i            = 2'($urandom_range(3));
    reg2Use_i            = 2'($urandom_range(3));
    reg3Use_i            = 2'($urandom_range(3));
    reg1Enable_i         = 1'($urandom_range(1));
    reg2Enable_i         = 1'($urandom_range(1));
    reg3Enable_i         = 1'($urandom_range(1));
    reg3IsImmediate_i    = 1'($urandom_range(1));
    bit1_i               = 1'($urandom_range(1));
    bit2_i               = 1'($urandom_range(1));
    reg2ValOrZero_i      = 1'($urandom_range(1));
    instructionAddress_i = addr;
    opcode_i             = opc;
    xOpcode_i            = 10'($urandom_range(1023));
    xOpcodeEnable_i      = 1'($urandom_range(1));
    functionalUnitCode_i = 3'($urandom_range(7));
    instructionFormat_i  = 5'($urandom_range(31));
    if (expect_out) exp_q.push_back(in_pkt());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 256'(valid_o), 256'(0));
    check({tag, "_stall"}, 256'(stall_o), 256'(0));
    check({tag, "_count"}, 256'(count_o), 256'(0));
    check({tag, "_overflow"}, 256'(overflow_o), 256'(0));
    check({tag, "_fields"}, 256'(out_pkt()), 256'(0));
  endtask

  // Scoreboard: every consumed packet must be the oldest expected one.
  always @(negedge clock_i) begin
    if (!reset_i && !flush_i && valid_o && ready_i) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_pkt: observed addr %0h expected no packet", instructionAddress_o);
      end
      if (exp_q.size() != 0) check("pkt", 256'(out_pkt()), 256'(exp_q.pop_front()));
    end
  end

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
    send(64'h0, 6'd0, 1'b0);
    enable_i = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    reset_i = 1'b0;

    // Single packet latency
    ready_i = 1'b1;
    send(64'h1000, 6'd14, 1'b1);
    tick();
    enable_i = 1'b0;
`ifndef DECODE_ISSUE_QUEUE_BYPASS_EN
    check("lat_valid_early", 256'(valid_o), 256'(0));
    check("lat_count", 256'(count_o), 256'(1));
    tick();
`endif
    check("lat_valid", 256'(valid_o), 256'(1));
    check("lat_addr", 256'(instructionAddress_o), 256'(64'h1000));
    check("lat_opcode", 256'(opcode_o), 256'(14));
    tick();
    check("lat_valid_drop", 256'(valid_o), 256'(0));

    // Fill with ready low: stall threshold, full, accept-on-pop, drop
    ready_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      int exp_cnt;
      send(64'h3000 + 64'(k), 6'(k), 1'b1);
      tick();
`ifdef DECODE_ISSUE_QUEUE_BYPASS_EN
      exp_cnt = k - 1;
`else
      exp_cnt = (k == 1) ? 1 : k - 1;
`endif
      check($sformatf("fill_count_%0d", k), 256'(count_o), 256'(exp_cnt));
      check($sformatf("fill_stall_%0d", k), 256'(stall_o), 256'(exp_cnt >= 5));
    end
    check("full_overflow", 256'(overflow_o), 256'(0));
    ready_i = 1'b1;
    send(64'h300A, 6'd10, 1'b1);
    tick();
    check("full_pop_count", 256'(count_o), 256'(8));
    check("full_pop_overflow", 256'(overflow_o), 256'(0));
    ready_i = 1'b0;
    send(64'h300B, 6'd11, 1'b0);
    tick();
    enable_i = 1'b0;
    check("drop_overflow", 256'(overflow_o), 256'(1));
    check("drop_count", 256'(count_o), 256'(8));
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("drain_q", 256'(exp_q.size()), 256'(0));
    check("drain_count", 256'(count_o), 256'(0));
    check("drain_valid", 256'(valid_o), 256'(0));
    check("drain_stall", 256'(stall_o), 256'(0));

    // Stream 20 packets with ready toggling
    for (int i = 0; i < 40; i++) begin
      ready_i = (i % 2 == 0);
      if (i % 2 == 0) send(64'h2000 + 64'(i * 2), 6'(i), 1'b1);
      else enable_i = 1'b0;
      tick();
    end
    enable_i = 1'b0;
    ready_i  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("stream_q", 256'(exp_q.size()), 256'(0));
    check("stream_count", 256'(count_o), 256'(0));

    // Flush with a concurrent write
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(64'h4000 + 64'(i), 6'(i), 1'b0);
      tick();
    end
    check("preflush_valid", 256'(valid_o), 256'(1));
    flush_i = 1'b1;
    send(64'h4444, 6'd44, 1'b0);
    tick();
    flush_i  = 1'b0;
    enable_i = 1'b0;
    check("flush_valid", 256'(valid_o), 256'(0));
    check("flush_count", 256'(count_o), 256'(0));
    check("flush_stall", 256'(stall_o), 256'(0));
    check("flush_overflow_kept", 256'(overflow_o), 256'(1));
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("postflush_valid", 256'(valid_o), 256'(0));

    // Reset mid-stream
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(64'h5000 + 64'(i), 6'(i), 1'b0);
      tick();
    end
    enable_i = 1'b0;
    check("prereset_valid", 256'(valid_o), 256'(1));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    check_reset_outputs("midreset");
    ready_i = 1'b1;
    send(64'h6000, 6'd7, 1'b1);
    tick();
    enable_i = 1'b0;
`ifndef DECODE_ISSUE_QUEUE_BYPASS_EN
    check("rlat_valid_early", 256'(valid_o), 256'(0));
    tick();
`endif
    check("rlat_valid", 256'(valid_o), 256'(1));
    check("rlat_addr", 256'(instructionAddress_o), 256'(64'h6000));
    tick(); tick();
    check("final_q", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
